prog_modcounter: RTL and testbench



---
 rtl/prog_counter_pkg.sv | 15 +
 rtl/tick_gen.sv | 45 ++++
 rtl/prog_modcounter.sv | 138 +++++++++++++
 tb/tb_prog_modcounter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_counter_pkg.sv
// Shared mode and direction encodings for the programmable board counter.
package prog_counter_pkg;

   typedef logic [2:0] mode_t;

   localparam mode_t MODE_UP     = 3'd0;
   localparam mode_t MODE_DOWN   = 3'd1;
   localparam mode_t MODE_BOUNCE = 3'd2;
   localparam mode_t MODE_LOAD   = 3'd3;
   localparam mode_t MODE_CLEAR  = 3'd4;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick strobe every PRESCALE enabled clock cycles.
// Ports: clk, rst (async active-low), en (freezes prescaler when 0),
//        tick (registered strobe, high the cycle after the prescaler holds PRESCALE-1).
module tick_gen #(
   parameter int unsigned PRESCALE = 100000000,
   parameter int unsigned PW       = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   // Wrap at PRESCALE-1 and flag the wrap as next cycle's tick.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (en) begin
         if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/prog_modcounter.sv
// Programmable modulus counter with up/down/bounce/load/clear/hold modes.
// Ports: clk, rst (async active-low), en (count enable), ctrl (mode),
//        data (load value); outputs count, t_count (thermometer), dir
//        (bounce direction), tick (prescaler strobe), tc (terminal-count
//        pulse), load_err (rejected-load pulse). All outputs registered.
module prog_modcounter
   import prog_counter_pkg::*;
#(
   parameter int unsigned MOD      = 16,
   parameter int unsigned W        = 4,
   parameter int unsigned PRESCALE = 100000000,
   parameter int unsigned PW       = 27
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [2:0]     ctrl,
   input  logic [W-1:0]   data,
   output logic [W-1:0]   count,
   output logic [MOD-1:0] t_count,
   output logic           dir,
   output logic           tick,
   output logic           tc,
   output logic           load_err
);

   localparam logic [W-1:0] CNT_MAX = W'(MOD - 1);

   mode_t          mode;
   logic [W-1:0]   count_q, count_d;
   logic [MOD-1:0] t_count_q, t_count_d;
   logic           dir_q, dir_d;
   logic           tc_q, tc_d;
   logic           err_q, err_d;

   assign mode = ctrl;

   tick_gen #(
      .PRESCALE (PRESCALE),
      .PW       (PW)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );

   // Counter next state; only evaluated on enabled tick cycles.
   always_comb begin
      count_d = count_q;
      dir_d   = dir_q;
      tc_d    = 1'b0;
      err_d   = 1'b0;
      if (en && tick) begin
         // Any non-bounce tick resets direction so bounce always restarts upward.
         dir_d = DIR_UP;
         case (mode)
            MODE_UP: begin
               if (count_q == CNT_MAX) begin
                  count_d = '0;
                  tc_d    = 1'b1;
               end else begin
                  count_d = count_q + W'(1);
               end
            end
            MODE_DOWN: begin
               if (count_q == '0) begin
                  count_d = CNT_MAX;
                  tc_d    = 1'b1;
               end else begin
                  count_d = count_q - W'(1);
               end
            end
            MODE_BOUNCE: begin
               dir_d = dir_q;
               if (dir_q == DIR_UP && count_q == CNT_MAX) begin
                  dir_d   = DIR_DOWN;
                  count_d = CNT_MAX - W'(1);
                  tc_d    = 1'b1;
               end else if (dir_q == DIR_DOWN && count_q == '0) begin
                  dir_d   = DIR_UP;
                  count_d = W'(1);
                  tc_d    = 1'b1;
               end else if (dir_q == DIR_UP) begin
                  count_d = count_q + W'(1);
               end else begin
                  count_d = count_q - W'(1);
               end
            end
            MODE_LOAD: begin
               // Out-of-range loads fall back to 0 so count never leaves 0..MOD-1.
               if (32'(data) < MOD) begin
                  count_d = data;
               end else begin
                  count_d = '0;
                  err_d   = 1'b1;
               end
            end
            MODE_CLEAR: begin
               count_d = '0;
            end
            default: begin
            end
         endcase
      end
   end

   // Thermometer of the next count so it lines up with count.
   always_comb begin
      t_count_d = '0;
      for (int unsigned i = 0; i < MOD; i++) begin
         t_count_d[i] = (32'(count_d) > i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q   <= '0;
         t_count_q <= '0;
         dir_q     <= DIR_UP;
         tc_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         t_count_q <= t_count_d;
         dir_q     <= dir_d;
         tc_q      <= tc_d;
         err_q     <= err_d;
      end
   end

   assign count    = count_q;
   assign t_count  = t_count_q;
   assign dir      = dir_q;
   assign tc       = tc_q;
   assign load_err = err_q;

endmodule

// File: tb/tb_prog_modcounter.sv
// Bench for prog_modcounter: MOD=10, W=4, PRESCALE=4 main instance plus a
// PRESCALE=1 instance sharing the same inputs.
module tb_prog_modcounter;

   localparam int unsigned MOD = 10;
   localparam int unsigned W   = 4;
   localparam int unsigned P   = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           en  = 1'b0;
   logic [2:0]     ctrl = 3'd0;
   logic [W-1:0]   data = '0;

   logic [W-1:0]   count,   count1;
   logic [MOD-1:0] t_count, t_count1;
   logic           dir, dir1, tick, tick1, tc, tc1, load_err, load_err1;

   prog_modcounter #(.MOD(MOD), .W(W), .PRESCALE(P), .PW(3)) dut (
      .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .data(data),
      .count(count), .t_count(t_count), .dir(dir), .tick(tick),
      .tc(tc), .load_err(load_err)
   );

   prog_modcounter #(.MOD(MOD), .W(W), .PRESCALE(1), .PW(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .data(data),
      .count(count1), .t_count(t_count1), .dir(dir1), .tick(tick1),
      .tc(tc1), .load_err(load_err1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0] ctrl;
      logic [3:0] data;
      logic [3:0] count;
      logic       tc;
      logic       dir;
      logic       err;
   } vec_t;

   typedef struct {
      logic [3:0] count;
      logic [9:0] t;
      logic       tc;
      logic       dir;
      logic       err;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   last_tick = 0;

   function automatic logic [9:0] therm(input logic [3:0] c);
      logic [10:0] one;
      one = 11'd1;
      return 10'((one << c) - 11'd1);
   endfunction

   function automatic void add(input int c, input int d, input int n,
                               input int t, input int dr, input int e);
      vec_t v;
      v.ctrl  = 3'(c);
      v.data  = 4'(d);
      v.count = 4'(n);
      v.tc    = 1'(t);
      v.dir   = 1'(dr);
      v.err   = 1'(e);
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Bounded wait for the main instance's tick, sampled at negedges.
   task automatic wait_tick(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (tick) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
      checks++;
      errors++;
      $display("FAIL tick_timeout: no tick within 50 cycles (t=%0t)", $time);
   endtask

   // Drive one vector, push its expectation on the tick, compare the cycle after.
   task automatic run_vec(input int idx, input vec_t v);
      bit   ok;
      exp_t e, g;
      string p;
      p = $sformatf("v%0d", idx);
      ctrl = v.ctrl;
      data = v.data;
      wait_tick(ok);
      if (!ok) return;
      check({p, "_tick_gap"}, 32'(cyc - last_tick), 32'(P));
      last_tick = cyc;
      e.count = v.count;
      e.t     = therm(v.count);
      e.tc    = v.tc;
      e.dir   = v.dir;
      e.err   = v.err;
      sb.push_back(e);
      @(negedge clk);
      g = sb.pop_front();
      check({p, "_count"},    32'(count),    32'(g.count));
      check({p, "_t_count"},  32'(t_count),  32'(g.t));
      check({p, "_dir"},      32'(dir),      32'(g.dir));
      check({p, "_tc"},       32'(tc),       32'(g.tc));
      check({p, "_load_err"}, 32'(load_err), 32'(g.err));
      @(negedge clk);
      check({p, "_tc_width"},  32'(tc),       32'd0);
      check({p, "_err_width"}, 32'(load_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_count",   32'(count),    32'd0);
      check("rst_t_count", 32'(t_count),  32'd0);
      check("rst_dir",     32'(dir),      32'd0);
      check("rst_tick",    32'(tick),     32'd0);
      check("rst_tc",      32'(tc),       32'd0);
      check("rst_err",     32'(load_err), 32'd0);

      // Up wrap
      for (int i = 1; i <= 11; i++) add(0, 0, i % 10, (i == 10) ? 1 : 0, 0, 0);
      // Clear, down wrap, clear
      add(4, 0, 0, 0, 0, 0);
      add(1, 0, 9, 1, 0, 0);
      add(1, 0, 8, 0, 0, 0);
      add(4, 0, 0, 0, 0, 0);
      // Bounce from 0
      for (int i = 1; i <= 9; i++) add(2, 0, i, 0, 0, 0);
      add(2, 0, 8, 1, 1, 0);
      for (int i = 7; i >= 0; i--) add(2, 0, i, 0, 1, 0);
      add(2, 0, 1, 1, 0, 0);
      add(2, 0, 2, 0, 0, 0);
      // Load range, including both boundaries
      add(3, 7, 7, 0, 0, 0);
      add(3, 12, 0, 0, 0, 1);
      add(3, 9, 9, 0, 0, 0);
      add(3, 10, 0, 0, 0, 1);
      add(3, 5, 5, 0, 0, 0);
      // Hold codes ignore data
      add(6, 3, 5, 0, 0, 0);
      add(5, 0, 5, 0, 0, 0);
      add(7, 15, 5, 0, 0, 0);
      // Bounce down then switch to up: dir clears
      add(3, 9, 9, 0, 0, 0);
      add(2, 0, 8, 1, 1, 0);
      add(0, 0, 9, 0, 0, 0);
      add(2, 0, 8, 1, 1, 0);

      rst = 1'b1;
      en  = 1'b1;
      last_tick = cyc;
      for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

      // Enable low: nothing moves even with ctrl = up
      en   = 1'b0;
      ctrl = 3'd0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("en_off_tick", 32'(tick), 32'd0);
      end
      check("en_off_count", 32'(count), 32'd8);
      check("en_off_dir",   32'(dir),   32'd1);
      check("en_off_tc",    32'(tc),    32'd0);

      // Async reset mid-prescale, between clock edges
      en = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_count",   32'(count),   32'd0);
      check("arst_t_count", 32'(t_count), 32'd0);
      check("arst_dir",     32'(dir),     32'd0);
      check("arst_tick",    32'(tick),    32'd0);
      check("arst_tc",      32'(tc),      32'd0);
      check("arst_err",     32'(load_err),32'd0);
      @(negedge clk);
      rst = 1'b1;
      last_tick = cyc;
      vecs.delete();
      add(0, 0, 1, 0, 0, 0);
      run_vec(100, vecs[0]);

      // PRESCALE = 1 instance: tick every cycle, up count with wrap
      rst  = 1'b0;
      ctrl = 3'd0;
      en   = 1'b1;
      @(negedge clk);
      check("p1_rst_count", 32'(count1), 32'd0);
      rst = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check($sformatf("p1_tick_%0d", k),  32'(tick1),  32'd1);
         check($sformatf("p1_count_%0d", k), 32'(count1), 32'((k - 1) % 10));
         check($sformatf("p1_tc_%0d", k),    32'(tc1),    32'(k == 11));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
